// File: rtl/fmul_norm_round_if.sv
`default_nettype none
// ============================================================================
// Module   : fmul_norm_round_if
// Brief    : Product-beat input and packed-result output handshake bundle
// Revision : 1.0
// ============================================================================
interface fmul_norm_round_if;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [9:0]  in_exp;
    logic [47:0] in_prod;
    logic [1:0]  in_special;
    logic [1:0]  rm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [2:0]  out_flags;

    modport master (
        output in_valid, in_sign, in_exp, in_prod, in_special, rm, out_ready,
        input  in_ready, out_valid, out_result, out_flags
    );

    modport slave (
        input  in_valid, in_sign, in_exp, in_prod, in_special, rm, out_ready,
        output in_ready, out_valid, out_result, out_flags
    );
endinterface
`default_nettype wire

// File: rtl/fmul_norm_round.sv
`default_nettype none
// ============================================================================
// Module   : fmul_norm_round
// Brief    : FP32 multiply back end: normalize (S1), round/pack (S2), elastic
// Revision : 1.0
// ============================================================================
module fmul_norm_round #(
    parameter logic [31:0] QNAN = 32'h7FC00000
) (
    input  logic             clk,
    input  logic             clrn,
    fmul_norm_round_if.slave bus
);
    localparam logic [1:0] c_SP_NORMAL = 2'b00;
    localparam logic [1:0] c_SP_ZERO   = 2'b01;
    localparam logic [1:0] c_SP_INF    = 2'b10;
    localparam logic [1:0] c_SP_NAN    = 2'b11;
    localparam logic [1:0] c_RM_RNE    = 2'b00;
    localparam logic [1:0] c_RM_RZ     = 2'b01;
    localparam logic [1:0] c_RM_RP     = 2'b10;
    localparam logic [1:0] c_RM_RM     = 2'b11;
    localparam logic signed [11:0] c_EXP_MAX = 12'sd255;

    logic               s1_valid_q,   s1_valid_d;
    logic               s1_sign_q,    s1_sign_d;
    logic signed [11:0] s1_exp_q,     s1_exp_d;
    logic [22:0]        s1_frac_q,    s1_frac_d;
    logic               s1_guard_q,   s1_guard_d;
    logic               s1_sticky_q,  s1_sticky_d;
    logic [1:0]         s1_special_q, s1_special_d;
    logic [1:0]         s1_rm_q,      s1_rm_d;
    logic               out_valid_q,  out_valid_d;
    logic [31:0]        out_result_q, out_result_d;
    logic [2:0]         out_flags_q,  out_flags_d;

    logic               w_s2_load;
    logic               w_in_ready;
    logic signed [11:0] w_exp_in;
    logic               w_inc;
    logic [23:0]        w_sum;
    logic signed [11:0] w_exp_r;
    logic               w_inexact;
    logic               w_max_finite;
    logic [31:0]        w_result;
    logic [2:0]         w_flags;

    assign w_s2_load  = ~out_valid_q | bus.out_ready;
    assign w_in_ready = ~s1_valid_q | w_s2_load;
    assign w_exp_in   = {{2{bus.in_exp[9]}}, bus.in_exp};

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_result = out_result_q;
    assign bus.out_flags  = out_flags_q;

    // S1: normalize the product so the hidden bit sits just above frac
    always_comb begin
        s1_valid_d   = s1_valid_q;
        s1_sign_d    = s1_sign_q;
        s1_exp_d     = s1_exp_q;
        s1_frac_d    = s1_frac_q;
        s1_guard_d   = s1_guard_q;
        s1_sticky_d  = s1_sticky_q;
        s1_special_d = s1_special_q;
        s1_rm_d      = s1_rm_q;
        if (w_in_ready) begin
            s1_valid_d = bus.in_valid;
            if (bus.in_valid) begin
                s1_sign_d    = bus.in_sign;
                s1_rm_d      = bus.rm;
                s1_special_d = (bus.in_special == c_SP_NORMAL && bus.in_prod == 48'h0)
                             ? c_SP_ZERO : bus.in_special;
                if (bus.in_prod[47]) begin
                    s1_frac_d   = bus.in_prod[46:24];
                    s1_guard_d  = bus.in_prod[23];
                    s1_sticky_d = |bus.in_prod[22:0];
                    s1_exp_d    = w_exp_in + 12'sd1;
                end else begin
                    s1_frac_d   = bus.in_prod[45:23];
                    s1_guard_d  = bus.in_prod[22];
                    s1_sticky_d = |bus.in_prod[21:0];
                    s1_exp_d    = w_exp_in;
                end
            end
        end
    end

    // S2: round, detect range errors, pack
    always_comb begin
        w_inc = 1'b0;
        case (s1_rm_q)
            c_RM_RNE: w_inc = s1_guard_q & (s1_sticky_q | s1_frac_q[0]);
            c_RM_RZ:  w_inc = 1'b0;
            c_RM_RP:  w_inc = ~s1_sign_q & (s1_guard_q | s1_sticky_q);
            default:  w_inc = s1_sign_q & (s1_guard_q | s1_sticky_q);
        endcase
        w_sum        = {1'b0, s1_frac_q} + {23'h0, w_inc};
        w_exp_r      = s1_exp_q + (w_sum[23] ? 12'sd1 : 12'sd0);
        w_inexact    = s1_guard_q | s1_sticky_q;
        w_max_finite = (s1_rm_q == c_RM_RZ)
                     | ((s1_rm_q == c_RM_RP) & s1_sign_q)
                     | ((s1_rm_q == c_RM_RM) & ~s1_sign_q);
        w_result     = {s1_sign_q, w_exp_r[7:0], w_sum[22:0]};
        w_flags      = {2'b00, w_inexact};
        case (s1_special_q)
            c_SP_ZERO: begin
                w_result = {s1_sign_q, 31'h0};
                w_flags  = 3'b000;
            end
            c_SP_INF: begin
                w_result = {s1_sign_q, 8'hFF, 23'h0};
                w_flags  = 3'b000;
            end
            c_SP_NAN: begin
                w_result = QNAN;
                w_flags  = 3'b000;
            end
            default: begin
                if (w_exp_r >= c_EXP_MAX) begin
                    w_result = w_max_finite ? {s1_sign_q, 31'h7F7FFFFF}
                                            : {s1_sign_q, 8'hFF, 23'h0};
                    w_flags  = 3'b101;
                end else if (w_exp_r <= 12'sd0) begin
                    w_result = {s1_sign_q, 31'h0};
                    w_flags  = 3'b011;
                end
            end
        endcase
    end

    always_comb begin
        out_valid_d  = out_valid_q;
        out_result_d = out_result_q;
        out_flags_d  = out_flags_q;
        if (w_s2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_result_d = w_result;
                out_flags_d  = w_flags;
            end
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            s1_valid_q   <= 1'b0;
            s1_sign_q    <= 1'b0;
            s1_exp_q     <= 12'sd0;
            s1_frac_q    <= 23'h0;
            s1_guard_q   <= 1'b0;
            s1_sticky_q  <= 1'b0;
            s1_special_q <= 2'b00;
            s1_rm_q      <= 2'b00;
            out_valid_q  <= 1'b0;
            out_result_q <= 32'h0;
            out_flags_q  <= 3'b000;
        end else begin
            s1_valid_q   <= s1_valid_d;
            s1_sign_q    <= s1_sign_d;
            s1_exp_q     <= s1_exp_d;
            s1_frac_q    <= s1_frac_d;
            s1_guard_q   <= s1_guard_d;
            s1_sticky_q  <= s1_sticky_d;
            s1_special_q <= s1_special_d;
            s1_rm_q      <= s1_rm_d;
            out_valid_q  <= out_valid_d;
            out_result_q <= out_result_d;
            out_flags_q  <= out_flags_d;
        end
    end
endmodule
`default_nettype wire

// File: doc/fmul_norm_round.md
FMUL_NORM_ROUND -- requirements
Module: fmul_norm_round

Interface
REQ-001 The block SHALL have exactly one clock and one reset: a single clock, and a reset that is asynchronous and active-low.
REQ-002 Parameter: QNAN, default 32'h7FC00000, the canonical NaN pattern driven for NaN results.
REQ-003 Port: clk  input  1  rising-edge clock.
REQ-004 Port: clrn  input  1  asynchronous active-low reset.
REQ-005 Port: in_valid  input  1  upstream product beat valid.
REQ-006 Port: in_ready  output  1  block accepts a beat this cycle.
REQ-007 Port: in_sign  input  1  result sign (sign_a XOR sign_b).
REQ-008 Port: in_exp  input  10  two's-complement exponent: exp_a + exp_b - 127.
REQ-009 Port: in_prod  input  48  24x24 significand product from the multiplier stage.
REQ-010 Port: in_special  input  2  class of the beat: 00 = normal, 01 = zero, 10 = infinity, 11 = NaN.
REQ-011 Port: rm  input  2  rounding mode, sampled with the beat: 00 = nearest-even, 01 = toward zero, 10 = toward +inf, 11 = toward -inf.
REQ-012 Port: out_valid  output  1  result valid.
REQ-013 Port: out_ready  input  1  downstream accepts the result.
REQ-014 Port: out_result  output  32  IEEE-754 single-precision result.
REQ-015 Port: out_flags  output  3  {overflow, underflow, inexact}.

Function
REQ-016 A beat SHALL transfer on a rising clk edge when in_valid=1 and in_ready=1; a result SHALL transfer when out_valid=1 and out_ready=1.
REQ-017 The pipeline SHALL have 2 registered stages: S1 (normalize) and S2 (round/pack/output); latency SHALL be 2 cycles with no stall.
REQ-018 S2 SHALL load when it is empty or out_ready=1; S1 SHALL advance under the same condition; in_ready SHALL equal (S1 empty) OR (S1 advancing). in_ready is combinational.
REQ-019 While out_valid=1 and out_ready=0, out_result and out_flags SHALL hold stable; no beat SHALL be lost, duplicated or reordered; sustained throughput SHALL be 1 beat/cycle.
REQ-020 S1 normalize, prod[47]=1: frac = prod[46:24], guard = prod[23], sticky = |prod[22:0], exp = in_exp + 1.
REQ-021 S1 normalize, prod[47]=0: frac = prod[45:23], guard = prod[22], sticky = |prod[21:0], exp = in_exp.
REQ-022 Rounding increment:
- RNE: guard & (sticky | frac[0]).
- RZ: 0.
- RP: ~sign & (guard | sticky).
- RM: sign & (guard | sticky).
REQ-023 If frac+increment carries out of 23 bits, frac SHALL become 0 and exp SHALL increment by 1.
REQ-024 inexact SHALL equal guard | sticky for normal results.
REQ-025 Overflow, final exp >= 255: overflow=1 and inexact=1. The result SHALL be ±inf, except for these cases, which give ±0x7F7FFFFF (max finite):
- RZ.
- RP with sign=1.
- RM with sign=0.
REQ-026 Underflow, final exp <= 0: the result SHALL flush to signed zero ({sign,31'b0}) with underflow=1 and inexact=1; there is no subnormal output.
REQ-027 Special beats SHALL set out_flags=000 and SHALL bypass rounding:
- in_special=01 gives {sign,31'b0}.
- in_special=10 gives {sign,8'hFF,23'b0}.
- in_special=11 gives QNAN.
REQ-028 A normal beat with in_prod=0 SHALL be treated as zero (REQ-027).
REQ-029 The exponent datapath SHALL be at least 11 bits signed internally, so that in_exp+2 never wraps.

Reset
REQ-030 With clrn=0, asynchronously: S1 and S2 valid SHALL be 0, out_valid=0, out_result=32'h0, out_flags=3'b000; in_ready SHALL read 1.
REQ-031 Reset asserted mid-operation SHALL discard every in-flight beat; the first beat after clrn rises SHALL emerge 2 cycles after its acceptance.

Verification
REQ-032 Normal product: in_prod=48'h900000000000, in_exp=127, sign=0, rm=00, out_ready=1 -> after 2 cycles out_result=32'h40100000 (2.25), flags=000.
REQ-033 Tie case: in_prod=48'h400000400000, in_exp=127, sign=0.
- rm=00 -> 32'h3F800000, flags=001.
- rm=10 -> 32'h3F800001, flags=001.
REQ-034 Overflow: in_prod=48'h800000000000, in_exp=254, sign=0.
- rm=00 -> 32'h7F800000, flags=101.
- rm=01 -> 32'h7F7FFFFF, flags=101.
REQ-035 Underflow: in_prod=48'h400000000000, in_exp=0, sign=1 -> 32'h80000000, flags=011. Special: in_special=11 -> 32'h7FC00000, flags=000.
REQ-036 Backpressure: stream 4 beats with out_ready=0 -> in_ready drops after 2 accepted, out_result stays stable; then out_ready=1 -> all 4 results emerge in order, one per cycle.
REQ-037 Reset mid-stream: pulse clrn low with both stages full -> out_valid=0 immediately (asynchronously); the next beat's result appears exactly 2 cycles after acceptance.
